// File: rtl/block_memory_unit_if.sv
// Block-transfer bus between the cache controller and main memory.
// The requester holds read/write/address/writedata until busywait drops.
interface block_memory_unit_if #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) ();
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_writedata,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_writedata,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/block_memory_unit.sv
// Main-memory model behind the cache controller: serialized 128-bit block
// reads/writes with a fixed LATENCY and a busywait handshake.
module block_memory_unit #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    block_memory_unit_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic               busy;
    logic               accept;
    logic               complete;
    logic [BLOCK_W-1:0] readdata_q;
    logic [BLOCK_W-1:0] mem_array [DEPTH];

    logic               req_write_p0;
    logic [IDX_W-1:0]   req_index_p0;
    logic [BLOCK_W-1:0] req_data_p0;

    // Upper address bits alias onto the same blocks by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.mem_address[ADDR_W-1:IDX_W];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                busy   = bus.mem_read | bus.mem_write;
                accept = busy;
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                busy     = 1'b1;
                complete = (count == LAT_CNT);
                if (complete) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_busywait = busy;
    assign bus.mem_readdata = readdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                count <= CNT_W'(1);
            else if (state == BUSY && !complete)
                count <= count + 1'b1;
        end
    end

    // Request capture at the acceptance edge; write wins over a simultaneous read.
    always_ff @(posedge clock) begin
        if (accept) begin
            req_write_p0 <= bus.mem_write;
            req_index_p0 <= bus.mem_address[IDX_W-1:0];
            req_data_p0  <= bus.mem_writedata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_array[i] <= '0;
        end else if (complete) begin
            if (req_write_p0)
                mem_array[req_index_p0] <= req_data_p0;
            else
                readdata_q <= mem_array[req_index_p0];
        end
    end
endmodule

// File: tb/tb_block_memory_unit.sv
// Directed bench for block_memory_unit: handshake timing, data integrity,
// write priority, aliasing, mid-operation reset and input isolation while busy.
module tb_block_memory_unit;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_mis;

    localparam logic [127:0] BLK_D  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] BLK_AA = {16{8'hAA}};
    localparam logic [127:0] BLK_V  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] BLK_W  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] BLK_Z  = 128'h0;

    block_memory_unit_if #(.ADDR_W(28), .BLOCK_W(128)) bus ();

    block_memory_unit #(
        .ADDR_W (28),
        .BLOCK_W(128),
        .DEPTH  (256),
        .LATENCY(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 in IDLE. Holds the request until busywait
    // drops, keeps it through the DONE cycle, then releases it.
    task automatic do_op(input string tag, input logic rd, input logic wr,
                         input logic [27:0] addr, input logic [127:0] data,
                         input bit scramble);
        int hi;
        hi = 0;
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.mem_address   = addr;
        bus.mem_writedata = data;
        @(negedge clock);
        while (bus.mem_busywait && hi < 50) begin
            hi++;
            if (scramble && hi >= 2) begin
                bus.mem_address   = addr + 28'(hi);
                bus.mem_writedata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clock);
        end
        check_val({tag, "_busy_cycles"}, 128'(hi), 128'd5);
        @(posedge clock);
        #1;
        check_val({tag, "_low_one_cycle"}, 128'(bus.mem_busywait), 128'd1);
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = addr;
        bus.mem_writedata = data;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_busywait", 128'(bus.mem_busywait), 128'd0);
        check_val("reset_readdata", bus.mem_readdata, BLK_Z);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Fresh memory reads back zero.
        do_op("rd_5", 1'b1, 1'b0, 28'h0000005, BLK_Z, 1'b0);
        check_val("rd_5_data", bus.mem_readdata, BLK_Z);

        // Write/read round trip; readdata holds across a write.
        do_op("wr_12", 1'b0, 1'b1, 28'h12, BLK_D, 1'b0);
        check_val("wr_12_rd_hold", bus.mem_readdata, BLK_Z);
        do_op("rd_12", 1'b1, 1'b0, 28'h12, BLK_Z, 1'b0);
        check_val("rd_12_data", bus.mem_readdata, BLK_D);

        // Simultaneous read+write executes as a write only.
        do_op("rw_3", 1'b1, 1'b1, 28'h3, BLK_AA, 1'b0);
        check_val("rw_3_rd_hold", bus.mem_readdata, BLK_D);
        do_op("rd_3", 1'b1, 1'b0, 28'h3, BLK_Z, 1'b0);
        check_val("rd_3_data", bus.mem_readdata, BLK_AA);

        // Aliasing through ignored upper address bits.
        do_op("wr_103", 1'b0, 1'b1, 28'h103, BLK_V, 1'b0);
        do_op("rd_003", 1'b1, 1'b0, 28'h003, BLK_Z, 1'b0);
        check_val("alias_data", bus.mem_readdata, BLK_V);

        // A request dropped before any edge is never accepted.
        bus.mem_read    = 1'b1;
        bus.mem_address = 28'h12;
        #1;
        check_val("pulse_busy_comb", 128'(bus.mem_busywait), 128'd1);
        @(negedge clock);
        bus.mem_read = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("pulse_not_accepted", 128'(bus.mem_busywait), 128'd0);
        check_val("pulse_rd_hold", bus.mem_readdata, BLK_V);

        // Reset during BUSY cycle 2 aborts the pending write.
        bus.mem_write     = 1'b1;
        bus.mem_address   = 28'h7;
        bus.mem_writedata = BLK_W;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_val("abort_busy_before", 128'(bus.mem_busywait), 128'd1);
        reset         = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        check_val("abort_busy_now", 128'(bus.mem_busywait), 128'd0);
        check_val("abort_readdata", bus.mem_readdata, BLK_Z);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_op("rd_7", 1'b1, 1'b0, 28'h7, BLK_Z, 1'b0);
        check_val("abort_write_discarded", bus.mem_readdata, BLK_Z);
        do_op("rd_12_cleared", 1'b1, 1'b0, 28'h12, BLK_Z, 1'b0);
        check_val("reset_cleared_array", bus.mem_readdata, BLK_Z);

        // Inputs changing during BUSY are ignored.
        do_op("scr_wr_20", 1'b0, 1'b1, 28'h20, BLK_W, 1'b1);
        do_op("scr_rd_20", 1'b1, 1'b0, 28'h20, BLK_Z, 1'b1);
        check_val("scr_data_20", bus.mem_readdata, BLK_W);
        do_op("rd_22", 1'b1, 1'b0, 28'h22, BLK_AA, 1'b0);
        check_val("scr_no_stray_write", bus.mem_readdata, BLK_Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
